// File: rtl/alu_pkg.sv
// ALU control codes, FSM state encoding and shift-op classification shared by the execute-stage ALU.
// Pure declarations: no latency, no backpressure.
package alu_pkg;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b01010;
  localparam logic [4:0] ALU_SLT = 5'b01011;
  localparam logic [4:0] ALU_SLL = 5'b00110;
  localparam logic [4:0] ALU_SRL = 5'b00111;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [4:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_ops.sv
// Single-cycle ALU ops (AND/OR/XOR/ADD/SUB/SLT) plus illegal-code decode; shifts are legal but yield 0 here.
// Purely combinational: zero latency, no backpressure.
module alu_comb_ops
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_ctrl)
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_XOR: result = op_a ^ op_b;
      ALU_ADD: result = op_a + op_b;
      ALU_SUB: result = op_a - op_b;
      ALU_SLT: result[0] = $signed(op_a) < $signed(op_b);
      ALU_SLL, ALU_SRL, ALU_SRA: result = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: 1-cycle logic/arith, shifts 1+shamt cycles (1 cycle with ALU_BARREL_SHIFT_EN).
// Result held in DONE until out_ready; in_ready low while busy or holding an unconsumed result.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  alu_state_e         state_q, state_d;
  logic               live_q;
  logic [XLEN-1:0]    result_q;
  logic               zero_q, illegal_q;
  logic [4:0]         kind_q;
  logic [SHAMT_W-1:0] cnt_q;

  logic               accept;
  logic               go_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    comb_result;
  logic               comb_illegal;
  logic [XLEN-1:0]    load_val;
  logic [XLEN-1:0]    step_val;

  alu_comb_ops #(.XLEN(XLEN)) u_comb_ops (
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .result   (comb_result),
    .illegal  (comb_illegal)
  );

  assign shamt     = op_b[SHAMT_W-1:0];
  // live_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = live_q && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  always_comb begin
    load_val = comb_result;
    go_shift = 1'b0;
    if (is_shift(alu_ctrl)) begin
`ifdef ALU_BARREL_SHIFT_EN
      case (alu_ctrl)
        ALU_SLL: load_val = op_a << shamt;
        ALU_SRL: load_val = op_a >> shamt;
        default: load_val = $unsigned($signed(op_a) >>> shamt);
      endcase
`else
      load_val = op_a;
      go_shift = (shamt != '0);
`endif
    end
  end

  always_comb begin
    case (kind_q)
      ALU_SLL: step_val = result_q << 1;
      ALU_SRL: step_val = result_q >> 1;
      default: step_val = {result_q[XLEN-1], result_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept)
          state_d = go_shift ? ST_SHIFT : ST_DONE;
        else if ((state_q == ST_DONE) && out_ready)
          state_d = ST_IDLE;
      end
      ST_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      live_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      kind_q    <= ALU_SLL;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (accept) begin
        result_q  <= load_val;
        zero_q    <= (load_val == '0);
        illegal_q <= comb_illegal;
        kind_q    <= alu_ctrl;
        cnt_q     <= shamt;
      end else if (state_q == ST_SHIFT) begin
        // result_q doubles as the shift working register; out_valid is low meanwhile.
        result_q <= step_val;
        zero_q   <= (step_val == '0);
        cnt_q    <= cnt_q - SHAMT_W'(1);
      end
    end
  end

endmodule
